// File: rtl/conv_encoder_framer_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its decoder.
// Both sides use these generator defaults and this parity helper, so the
// encoder and decoder always agree on the code polynomials.
package conv_encoder_framer_pkg;

  localparam int         K_DEF  = 3;
  localparam logic [2:0] G1_DEF = 3'b111;  // octal 7
  localparam logic [2:0] G0_DEF = 3'b101;  // octal 5

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  // XOR-reduce of the tapped register bits; callers mask with the generator.
  function automatic logic parity(input logic [7:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_framer_if.sv
// Handshake/stream bundle between the bit source, the encoder and the
// channel stage.
//   enable_i, d_in, abort_i : source -> encoder
//   ready_o                 : encoder accepts d_in this cycle
//   valid_o, d_out          : coded symbol {G1 parity, G0 parity}
//   sof_o, eof_o            : frame delimiters, qualified by valid_o
//   frame_ct_o              : completed-frame counter
interface conv_encoder_framer_if #(
  parameter int CT_W = 16
);
  logic            enable_i;
  logic            d_in;
  logic            abort_i;
  logic            ready_o;
  logic            valid_o;
  logic [1:0]      d_out;
  logic            sof_o;
  logic            eof_o;
  logic [CT_W-1:0] frame_ct_o;

  modport master (
    output enable_i, d_in, abort_i,
    input  ready_o, valid_o, d_out, sof_o, eof_o, frame_ct_o
  );

  modport slave (
    input  enable_i, d_in, abort_i,
    output ready_o, valid_o, d_out, sof_o, eof_o, frame_ct_o
  );
endinterface

// File: rtl/conv_encoder_framer_core.sv
// Shift register and generator parity of the convolutional encoder.
// Ports:
//   clk     : clock
//   bit_i   : current input bit (forced 0 by the caller during the tail)
//   load    : shift bit_i into the register this cycle
//   clear   : synchronous clear of the register
//   symbol  : combinational {G1 parity, G0 parity} of {bit_i, state}
module conv_encoder_framer_core
  import conv_encoder_framer_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G1 = G1_DEF,
  parameter logic [K-1:0] G0 = G0_DEF
) (
  input  logic       clk,
  input  logic       bit_i,
  input  logic       load,
  input  logic       clear,
  output logic [1:0] symbol
);

  // state[K-2] is the most recent past bit, state[0] the oldest.
  logic [K-2:0] state;
  logic [K-1:0] sr;

  assign sr     = {bit_i, state};
  assign symbol = {parity(8'(sr & G1)), parity(8'(sr & G0))};

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= '0;
    end else if (load) begin
      state <= {bit_i, state[K-2:1]};
    end
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with framing. Collects FRAME_LEN data bits
// per frame (or fewer when aborted), then appends K-1 zero tail bits so the
// decoder's trellis terminates in state 0.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active-low
//   bus  : slave side of conv_encoder_framer_if (input bits, coded symbols,
//          sof/eof flags, ready, completed-frame counter)
module conv_encoder_framer
  import conv_encoder_framer_pkg::*;
#(
  parameter int           K         = K_DEF,
  parameter logic [K-1:0] G1        = G1_DEF,
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter int           FRAME_LEN = 256,
  parameter int           CT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_encoder_framer_if.slave bus
);

  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam int TCW = $clog2(K);

  enc_state_t      fsm;
  logic [BCW-1:0]  bit_ct;
  logic [TCW-1:0]  tail_ct;
  logic [CT_W-1:0] frame_ct;

  logic            in_tail;
  logic            abort_hit;
  logic            accept;
  logic            core_bit;
  logic            core_load;
  logic [1:0]      symbol;

  logic            vld_p1;
  logic            sof_p1;
  logic            eof_p1;
  logic [1:0]      sym_p1;

  // Abort only matters inside a frame, and it takes priority over a bit
  // presented in the same cycle.
  assign in_tail   = (fsm == TAIL);
  assign abort_hit = (fsm == DATA) && bus.abort_i;
  assign accept    = bus.enable_i && !in_tail && !abort_hit;
  assign core_bit  = in_tail ? 1'b0 : bus.d_in;
  assign core_load = accept || in_tail;

  conv_encoder_framer_core #(
    .K  (K),
    .G1 (G1),
    .G0 (G0)
  ) u_core (
    .clk    (clk),
    .bit_i  (core_bit),
    .load   (core_load),
    .clear  (!rst),
    .symbol (symbol)
  );

  // ---- stage p1: framing FSM and registered symbol outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm      <= IDLE;
      bit_ct   <= '0;
      tail_ct  <= '0;
      frame_ct <= '0;
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      sym_p1   <= 2'b00;
    end else begin
      vld_p1 <= core_load;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      if (core_load) begin
        sym_p1 <= symbol;
      end
      case (fsm)
        IDLE: begin
          if (accept) begin
            sof_p1  <= 1'b1;
            bit_ct  <= BCW'(1);
            tail_ct <= '0;
            fsm     <= (FRAME_LEN == 1) ? TAIL : DATA;
          end
        end
        DATA: begin
          if (bus.abort_i) begin
            tail_ct <= '0;
            fsm     <= TAIL;
          end else if (accept) begin
            if (bit_ct == BCW'(FRAME_LEN - 1)) begin
              tail_ct <= '0;
              fsm     <= TAIL;
            end else begin
              bit_ct <= bit_ct + 1'b1;
            end
          end
        end
        TAIL: begin
          // The last tail symbol flushes the register back to state 0.
          if (tail_ct == TCW'(K - 2)) begin
            eof_p1   <= 1'b1;
            frame_ct <= frame_ct + 1'b1;
            bit_ct   <= '0;
            fsm      <= IDLE;
          end else begin
            tail_ct <= tail_ct + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.ready_o    = !in_tail;
  assign bus.valid_o    = vld_p1;
  assign bus.sof_o      = sof_p1;
  assign bus.eof_o      = eof_p1;
  assign bus.d_out      = sym_p1;
  assign bus.frame_ct_o = frame_ct;

endmodule
